// File: rtl/addmul_pkg.sv
// addmul_pkg: shared operand width, multiplier state type and saturation constants
package addmul_pkg;
   localparam int DATA_W = 16;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_e;
endpackage

// File: rtl/addition_multiply_if.sv
// addition_multiply_if: operand, start and result bundle between calculator controller and arithmetic engine
interface addition_multiply_if;
   import addmul_pkg::*;
   logic [DATA_W-1:0] INn1;
   logic [DATA_W-1:0] INn2;
   logic              sub;
   logic              start_add;
   logic              start_mul;
   logic [DATA_W-1:0] add_out;
   logic              add_finish;
   logic              add_ovf;
   logic [DATA_W-1:0] mul_out;
   logic              mul_finish;
   logic              mul_ovf;
   logic              mul_busy;
   modport master (
      output INn1, INn2, sub, start_add, start_mul,
      input  add_out, add_finish, add_ovf, mul_out, mul_finish, mul_ovf, mul_busy
   );
   modport slave (
      input  INn1, INn2, sub, start_add, start_mul,
      output add_out, add_finish, add_ovf, mul_out, mul_finish, mul_ovf, mul_busy
   );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: unsigned 16x16 shift-add multiplier, one iteration per cycle, IDLE/RUN/DONE control
module mult_seq
   import addmul_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic                accept,
   output logic                busy,
   output logic                done,
   output logic [2*DATA_W-1:0] prod
);
   mul_state_e          state_q, state_d;
   logic [2*DATA_W-1:0] mcand_q, mcand_d, acc_q, acc_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // state, operand and accumulator registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // next state: a start is taken in IDLE or DONE (back-to-back), never mid-run
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      accept   = start && state_q != RUN;
      if (accept) begin
         state_d  = RUN;
         mcand_d  = {{DATA_W{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (state_q == RUN) begin
         acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         state_d  = cnt_q == CNT_W'(DATA_W - 1) ? DONE : RUN;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign prod = acc_q;
endmodule

// File: rtl/addition_multiply.sv
// addition_multiply: signed 16-bit adder/subtractor and sequential multiplier; ADDMUL_SATURATE_EN selects saturating results
module addition_multiply
   import addmul_pkg::*;
(
   input logic                clk,
   input logic                nRST,
   addition_multiply_if.slave bus
);
   localparam int MSB = DATA_W - 1;
   logic [DATA_W-1:0]   add_out_q, add_out_d, mul_out_q, mul_out_d;
   logic                add_ovf_q, add_ovf_d, add_fin_q, add_fin_d;
   logic                mul_ovf_q, mul_ovf_d, mul_fin_q, mul_fin_d;
   logic                sign_q, sign_d;
   logic [DATA_W-1:0]   b_eff, sum, add_res, mag_a, mag_b, mul_res;
   logic                add_ovf_c, mul_ovf_c, accept, busy, done;
   logic [2*DATA_W-1:0] prod, sprod;

   mult_seq u_core (
      .clk    (clk),
      .rst    (nRST),
      .start  (bus.start_mul),
      .a      (mag_a),
      .b      (mag_b),
      .accept (accept),
      .busy   (busy),
      .done   (done),
      .prod   (prod)
   );

   // result, flag and sign registers
   always_ff @(posedge clk) begin
      if (nRST) begin
         add_out_q <= '0;
         add_ovf_q <= 1'b0;
         add_fin_q <= 1'b0;
         mul_out_q <= '0;
         mul_ovf_q <= 1'b0;
         mul_fin_q <= 1'b0;
         sign_q    <= 1'b0;
      end else begin
         add_out_q <= add_out_d;
         add_ovf_q <= add_ovf_d;
         add_fin_q <= add_fin_d;
         mul_out_q <= mul_out_d;
         mul_ovf_q <= mul_ovf_d;
         mul_fin_q <= mul_fin_d;
         sign_q    <= sign_d;
      end
   end

   // adder: subtract as A + ~B + 1; overflow when same-sign inputs give a result of the other sign
   always_comb begin
      b_eff     = bus.sub ? ~bus.INn2 : bus.INn2;
      sum       = bus.INn1 + b_eff + DATA_W'(bus.sub);
      add_ovf_c = (bus.INn1[MSB] == b_eff[MSB]) && (sum[MSB] != bus.INn1[MSB]);
`ifdef ADDMUL_SATURATE_EN
      add_res   = add_ovf_c ? (bus.INn1[MSB] ? SAT_NEG : SAT_POS) : sum;
`else
      add_res   = sum;
`endif
      add_out_d = bus.start_add ? add_res : add_out_q;
      add_ovf_d = bus.start_add ? add_ovf_c : add_ovf_q;
      add_fin_d = bus.start_add;
   end

   // multiplier sign handling: magnitudes into the core, sign re-applied to the 32-bit product on completion
   always_comb begin
      mag_a     = bus.INn1[MSB] ? -bus.INn1 : bus.INn1;
      mag_b     = bus.INn2[MSB] ? -bus.INn2 : bus.INn2;
      sign_d    = accept ? bus.INn1[MSB] ^ bus.INn2[MSB] : sign_q;
      sprod     = sign_q ? -prod : prod;
      mul_ovf_c = sprod[2*DATA_W-1:MSB] != {(DATA_W + 1){sprod[2*DATA_W-1]}};
`ifdef ADDMUL_SATURATE_EN
      mul_res   = mul_ovf_c ? (sprod[2*DATA_W-1] ? SAT_NEG : SAT_POS) : sprod[MSB:0];
`else
      mul_res   = sprod[MSB:0];
`endif
      mul_out_d = done ? mul_res : mul_out_q;
      mul_ovf_d = done ? mul_ovf_c : mul_ovf_q;
      mul_fin_d = done;
   end

   assign bus.add_out    = add_out_q;
   assign bus.add_ovf    = add_ovf_q;
   assign bus.add_finish = add_fin_q;
   assign bus.mul_out    = mul_out_q;
   assign bus.mul_ovf    = mul_ovf_q;
   assign bus.mul_finish = mul_fin_q;
   assign bus.mul_busy   = busy;
endmodule

// File: tb/tb_addition_multiply.sv
// tb_addition_multiply: directed vectors with a queue scoreboard checking value, overflow and completion cycle
module tb_addition_multiply;
   typedef struct {
      logic [15:0] v;
      logic        o;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   logic nRST;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t addq[$];
   exp_t mulq[$];

   addition_multiply_if bus();

   addition_multiply dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic logic [15:0] sel(input logic [15:0] wrap, input logic [15:0] sat);
`ifdef ADDMUL_SATURATE_EN
      return sat;
`else
      return wrap;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] ev, input logic eo);
      bus.INn1 = a;
      bus.INn2 = b;
      bus.sub = s;
      bus.start_add = 1'b1;
      addq.push_back('{ev, eo, cyc + 1});
      tick;
      bus.start_add = 1'b0;
   endtask

   // mode 1: ignored restart at E+5; mode 2: concurrent add at E+3
   task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ev, input logic eo, input int mode);
      int n;
      bus.INn1 = a;
      bus.INn2 = b;
      bus.start_mul = 1'b1;
      mulq.push_back('{ev, eo, cyc + 18});
      tick;
      bus.start_mul = 1'b0;
      bus.INn1 = 16'hAAAA;
      bus.INn2 = 16'h5555;
      n = 0;
      while (bus.mul_busy && n < 40) begin
         if (mode == 1 && n == 4) begin
            bus.INn1 = 16'd2;
            bus.INn2 = 16'd2;
            bus.start_mul = 1'b1;
         end
         if (mode == 1 && n == 5) bus.start_mul = 1'b0;
         if (mode == 2 && n == 2) begin
            bus.INn1 = 16'd1000;
            bus.INn2 = 16'd24;
            bus.sub = 1'b0;
            bus.start_add = 1'b1;
            addq.push_back('{16'd1024, 1'b0, cyc + 1});
         end
         if (mode == 2 && n == 3) bus.start_add = 1'b0;
         n++;
         tick;
      end
      check("mul_busy_cycles", n, 17);
      tick;
      check("mul_hold", bus.mul_out, ev);
      check("mul_ovf_hold", bus.mul_ovf, eo);
   endtask

   // monitor: every finish pulse must match the oldest outstanding expectation, including its cycle
   always @(negedge clk) begin
      exp_t e;
      if (bus.add_finish) begin
         if (addq.size() == 0) check("add_spurious_finish", 1, 0);
         else begin
            e = addq.pop_front();
            check("add_out", bus.add_out, e.v);
            check("add_ovf", bus.add_ovf, e.o);
            check("add_cycle", cyc, e.c);
         end
      end
      if (bus.mul_finish) begin
         if (mulq.size() == 0) check("mul_spurious_finish", 1, 0);
         else begin
            e = mulq.pop_front();
            check("mul_out", bus.mul_out, e.v);
            check("mul_ovf", bus.mul_ovf, e.o);
            check("mul_cycle", cyc, e.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      nRST = 1'b1;
      bus.INn1 = '0;
      bus.INn2 = '0;
      bus.sub = 1'b0;
      bus.start_add = 1'b0;
      bus.start_mul = 1'b0;
      repeat (3) tick;
      check("rst_add_out", bus.add_out, 0);
      check("rst_add_finish", bus.add_finish, 0);
      check("rst_add_ovf", bus.add_ovf, 0);
      check("rst_mul_out", bus.mul_out, 0);
      check("rst_mul_finish", bus.mul_finish, 0);
      check("rst_mul_ovf", bus.mul_ovf, 0);
      check("rst_mul_busy", bus.mul_busy, 0);
      nRST = 1'b0;
      tick;

      do_add(16'd100, 16'd23, 1'b0, 16'h007B, 1'b0);
      tick;
      check("add_pulse_one_cycle", bus.add_finish, 0);
      check("add_hold", bus.add_out, 16'h007B);
      do_add(16'd5, 16'd9, 1'b1, 16'hFFFC, 1'b0);
      do_add(16'h7FFF, 16'h0001, 1'b0, sel(16'h8000, 16'h7FFF), 1'b1);
      do_add(16'h8000, 16'h0001, 1'b1, sel(16'h7FFF, 16'h8000), 1'b1);
      do_add(16'h0000, 16'h8000, 1'b1, sel(16'h8000, 16'h7FFF), 1'b1);
      do_add(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0);
      tick;

      do_mul(16'hFFF4, 16'd11, 16'hFF7C, 1'b0, 1);
      do_mul(16'd300, 16'd300, sel(16'h5F90, 16'h7FFF), 1'b1, 2);
      do_mul(16'h8000, 16'h8000, sel(16'h0000, 16'h7FFF), 1'b1, 0);
      do_mul(16'hFED4, 16'd300, sel(16'hA070, 16'h8000), 1'b1, 0);
      do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 0);
      do_mul(16'h8000, 16'h0001, 16'h8000, 1'b0, 0);
      do_mul(16'hFF80, 16'd256, 16'h8000, 1'b0, 0);
      do_mul(16'd128, 16'd256, sel(16'h8000, 16'h7FFF), 1'b1, 0);

      bus.INn1 = 16'd7;
      bus.INn2 = 16'd9;
      bus.start_mul = 1'b1;
      tick;
      bus.start_mul = 1'b0;
      repeat (7) tick;
      nRST = 1'b1;
      tick;
      check("abort_mul_busy", bus.mul_busy, 0);
      check("abort_mul_out", bus.mul_out, 0);
      check("abort_mul_ovf", bus.mul_ovf, 0);
      check("abort_add_out", bus.add_out, 0);
      check("abort_add_ovf", bus.add_ovf, 0);
      nRST = 1'b0;
      repeat (20) tick;
      check("abort_no_late_busy", bus.mul_busy, 0);
      do_mul(16'd3, 16'd4, 16'h000C, 1'b0, 0);

      repeat (5) tick;
      check("addq_drained", addq.size(), 0);
      check("mulq_drained", mulq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
